cronometro_voltas: RTL

- Parametrised successor stopwatch: centiseconds, seconds and minutes, counted from a configurable prescaled tick.
- Adds start/stop command control, lap capture with a frozen display while counting continues, explicit clear, and a sticky overflow flag.
- Sits between the debounced button front-end and the display driver; commands arrive as clean one-cycle pulses.

---
 rtl/cronometro_pkg.sv | 26 ++
 rtl/cronometro_voltas_contador.sv | 27 ++
 rtl/cronometro_voltas.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared types and helpers for the lap stopwatch.
// Holds the state enum, the field limits and the BCD helper.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } crono_estado_e;

  localparam int CENT_MAX = 99;
  localparam int SEG_MAX  = 59;

  // Two-digit packed BCD, tens in [7:4]; valid for 0..99.
  function automatic logic [7:0] to_bcd8(
    input logic [6:0] v
  );
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 7'd10);
    u = 4'(v % 7'd10);
    return {t, u};
  endfunction

endpackage

// File: rtl/cronometro_voltas_contador.sv
// contador_mod: one wrapping digit-field counter of the stopwatch cascade.
// Ports: clk, reset (sync, high), clr, en -> q, carry (en && q==MAX).
module contador_mod #(
  parameter int MAX = 99,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  assign carry = en && (q == MAXV);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= carry ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/cronometro_voltas.sv
// cronometro_voltas: centisecond/second/minute stopwatch with lap hold,
// clear and sticky overflow. Optional BCD outputs: CRONOMETRO_BCD_EN.
// In : clk, reset (sync, high), start_stop, lap, clear (1-cycle pulses)
// Out: cent_seg[6:0], seg[5:0], min[MIN_W-1:0], running, lap_hold,
//      overflow; with CRONOMETRO_BCD_EN also cent_bcd, seg_bcd, min_bcd.
module cronometro_voltas
  import cronometro_pkg::*;
#(
  parameter  int CLK_DIV = 1,
  parameter  int MIN_MAX = 59,
  localparam int MIN_W   =
    ($clog2(MIN_MAX + 1) < 1) ? 1 : $clog2(MIN_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  output logic [6:0]       cent_seg,
  output logic [5:0]       seg,
  output logic [MIN_W-1:0] min,
  output logic             running,
  output logic             lap_hold,
  output logic             overflow
`ifdef CRONOMETRO_BCD_EN
  ,
  output logic [7:0]       cent_bcd,
  output logic [7:0]       seg_bcd,
  output logic [7:0]       min_bcd
`endif
);

  localparam int PW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(CLK_DIV - 1);

  crono_estado_e est;
  crono_estado_e nxt;

  logic [PW-1:0]    presc;
  logic             tick;
  logic             do_clr;
  logic             lap_cap;

  logic [6:0]       cent_q;
  logic [5:0]       seg_q;
  logic [MIN_W-1:0] min_q;
  logic             c_carry;
  logic             s_carry;
  logic             m_carry;

  logic [6:0]       lap_c;
  logic [5:0]       lap_s;
  logic [MIN_W-1:0] lap_m;

  assign running  = (est == RUN) || (est == LAP);
  assign lap_hold = (est == LAP);
  assign tick     = running && (presc == PMAX);

  // A higher-priority pulse in the same cycle masks lap and clear.
  assign lap_cap = (est == RUN) && !start_stop && lap;
  assign do_clr  = (est == STOP) && !start_stop
                   && !lap && clear;

  always_comb begin
    nxt = est;
    case (est)
      IDLE: begin
        if (start_stop) nxt = RUN;
      end
      RUN: begin
        if (start_stop)  nxt = STOP;
        else if (lap)    nxt = LAP;
      end
      LAP: begin
        if (start_stop)  nxt = STOP;
        else if (lap)    nxt = RUN;
      end
      STOP: begin
        if (start_stop)  nxt = RUN;
        else if (do_clr) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) est <= IDLE;
    else       est <= nxt;
  end

  // Held in STOP so a resumed run keeps its fractional tick.
  always_ff @(posedge clk) begin
    if (reset || do_clr) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  contador_mod #(
    .MAX (CENT_MAX),
    .W   (7)
  ) u_cent (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clr),
    .en    (tick),
    .q     (cent_q),
    .carry (c_carry)
  );

  contador_mod #(
    .MAX (SEG_MAX),
    .W   (6)
  ) u_seg (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clr),
    .en    (c_carry),
    .q     (seg_q),
    .carry (s_carry)
  );

  contador_mod #(
    .MAX (MIN_MAX),
    .W   (MIN_W)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clr),
    .en    (s_carry),
    .q     (min_q),
    .carry (m_carry)
  );

  always_ff @(posedge clk) begin
    if (reset || do_clr) begin
      overflow <= 1'b0;
    end else if (m_carry) begin
      overflow <= 1'b1;
    end
  end

  // Captures the count as it stood before this edge's increment.
  always_ff @(posedge clk) begin
    if (reset || do_clr) begin
      lap_c <= '0;
      lap_s <= '0;
      lap_m <= '0;
    end else if (lap_cap) begin
      lap_c <= cent_q;
      lap_s <= seg_q;
      lap_m <= min_q;
    end
  end

  assign cent_seg = lap_hold ? lap_c : cent_q;
  assign seg      = lap_hold ? lap_s : seg_q;
  assign min      = lap_hold ? lap_m : min_q;

`ifdef CRONOMETRO_BCD_EN
  if (MIN_MAX > 99) begin : g_bcd_range
    $error("MIN_MAX must be <= 99 with BCD");
  end

  assign cent_bcd = to_bcd8(cent_seg);
  assign seg_bcd  = to_bcd8({1'b0, seg});
  assign min_bcd  = to_bcd8(7'(min));
`endif

endmodule
